// File: rtl/blu_pkg.sv
// Shared definitions for the NTT butterfly pipeline.
//   bu_mode_e : per-beat butterfly mode (00 bypass, 01 CT, 10 GS, 11 bypass)
//   Q_DEFAULT : default modulus (Dilithium prime)
//   mod_add / mod_sub : modular add/sub on operands already reduced below q
package blu_pkg;

  typedef enum logic [1:0] {
    BYPASS = 2'b00,
    CT     = 2'b01,
    GS     = 2'b10
  } bu_mode_e;

  localparam longint unsigned Q_DEFAULT = 64'd8380417;

  // Operands are widened to this width so one function serves any DATA_WIDTH.
  localparam int unsigned MOD_W = 64;

  function automatic logic [MOD_W-1:0] mod_add(input logic [MOD_W-1:0] a,
                                               input logic [MOD_W-1:0] b,
                                               input logic [MOD_W-1:0] q);
    logic [MOD_W-1:0] s;
    s = a + b;
    return (s >= q) ? s - q : s;
  endfunction

  function automatic logic [MOD_W-1:0] mod_sub(input logic [MOD_W-1:0] a,
                                               input logic [MOD_W-1:0] b,
                                               input logic [MOD_W-1:0] q);
    return (a >= b) ? a - b : a + q - b;
  endfunction

endpackage

// File: rtl/bu_stage.sv
// One butterfly stage: two register levels sharing the pipeline enable.
//   CT : level 1 holds (a, b*z mod q),  level 2 holds (a+t, a-t) mod q
//   GS : level 1 holds (a+b, a-b) mod q, level 2 holds (s, d*z mod q)
//   other modes pass a and b through with identical latency.
// Ports: clk/rst_n (async active-low), en (advance), clear (drop valids),
//   in_* beat entering the stage, out_* beat leaving level 2, busy = any
//   valid held in this stage. The full zeta vector travels with the beat;
//   this stage uses slice STAGE.
module bu_stage
  import blu_pkg::*;
#(
  parameter int unsigned     DATA_WIDTH = 32,
  parameter int unsigned     NUM_STAGES = 2,
  parameter int unsigned     STAGE      = 0,
  parameter longint unsigned Q          = Q_DEFAULT
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             clear,
  input  logic                             in_valid,
  input  logic [1:0]                       in_mode,
  input  logic [DATA_WIDTH-1:0]            in_a,
  input  logic [DATA_WIDTH-1:0]            in_b,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] in_zeta,
  output logic                             out_valid,
  output logic [1:0]                       out_mode,
  output logic [DATA_WIDTH-1:0]            out_a,
  output logic [DATA_WIDTH-1:0]            out_b,
  output logic [NUM_STAGES*DATA_WIDTH-1:0] out_zeta,
  output logic                             busy
);

  localparam int unsigned ZW = NUM_STAGES * DATA_WIDTH;
  localparam int unsigned PW = 2 * DATA_WIDTH;

  function automatic logic [DATA_WIDTH-1:0] add_q(input logic [DATA_WIDTH-1:0] x,
                                                  input logic [DATA_WIDTH-1:0] y);
    return DATA_WIDTH'(mod_add(MOD_W'(x), MOD_W'(y), MOD_W'(Q)));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sub_q(input logic [DATA_WIDTH-1:0] x,
                                                  input logic [DATA_WIDTH-1:0] y);
    return DATA_WIDTH'(mod_sub(MOD_W'(x), MOD_W'(y), MOD_W'(Q)));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] mul_q(input logic [DATA_WIDTH-1:0] x,
                                                  input logic [DATA_WIDTH-1:0] y);
    logic [PW-1:0] p;
    p = PW'(x) * PW'(y);
    return DATA_WIDTH'(p % PW'(Q));
  endfunction

  logic                  valid1_q, valid2_q;
  logic [1:0]            mode1_q, mode2_q;
  logic [DATA_WIDTH-1:0] a1_q, b1_q, a2_q, b2_q;
  logic [DATA_WIDTH-1:0] a1_d, b1_d, a2_d, b2_d;
  logic [ZW-1:0]         zeta1_q, zeta2_q;
  logic [DATA_WIDTH-1:0] z1, z2;

  assign z1 = in_zeta[STAGE*DATA_WIDTH +: DATA_WIDTH];
  assign z2 = zeta1_q[STAGE*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    a1_d = in_a;
    b1_d = in_b;
    case (bu_mode_e'(in_mode))
      CT: b1_d = mul_q(in_b, z1);
      GS: begin
        a1_d = add_q(in_a, in_b);
        b1_d = sub_q(in_a, in_b);
      end
      default: ;
    endcase
  end

  always_comb begin
    a2_d = a1_q;
    b2_d = b1_q;
    case (bu_mode_e'(mode1_q))
      CT: begin
        a2_d = add_q(a1_q, b1_q);
        b2_d = sub_q(a1_q, b1_q);
      end
      GS: b2_d = mul_q(b1_q, z2);
      default: ;
    endcase
  end

  // clear outranks en so a flush also drops a beat stalled at the output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else if (clear) begin
      valid1_q <= 1'b0;
      valid2_q <= 1'b0;
    end else if (en) begin
      valid1_q <= in_valid;
      valid2_q <= valid1_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode1_q <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      zeta1_q <= '0;
      mode2_q <= '0;
      a2_q    <= '0;
      b2_q    <= '0;
      zeta2_q <= '0;
    end else if (en) begin
      mode1_q <= in_mode;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      zeta1_q <= in_zeta;
      mode2_q <= mode1_q;
      a2_q    <= a2_d;
      b2_q    <= b2_d;
      zeta2_q <= zeta1_q;
    end
  end

  assign out_valid = valid2_q;
  assign out_mode  = mode2_q;
  assign out_a     = a2_q;
  assign out_b     = b2_q;
  assign out_zeta  = zeta2_q;
  assign busy      = valid1_q | valid2_q;

endmodule

// File: rtl/ntt_bu_pipeline.sv
// Chain of NUM_STAGES modular butterfly stages (CT for NTT, GS for INTT,
// bypass) with a single global enable: the whole pipe advances whenever the
// output slot is empty or being accepted. Latency is 2*NUM_STAGES cycles.
// Ports: clk_i, reset_ni (async active-low), clear_i (sync flush),
//   in_valid_i/in_ready_o + mode_i, data1_i, data2_i, zeta_i (stage k twiddle
//   at zeta_i[k*DATA_WIDTH +: DATA_WIDTH]) on the input side,
//   out_valid_o/out_ready_i + data1_o, data2_o, mode_o on the output side,
//   busy_o high while any beat is in flight.
module ntt_bu_pipeline
  import blu_pkg::*;
#(
  parameter int unsigned     DATA_WIDTH = 32,
  parameter int unsigned     NUM_STAGES = 2,
  parameter longint unsigned Q          = Q_DEFAULT
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic                             clear_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic [1:0]                       mode_i,
  input  logic [DATA_WIDTH-1:0]            data1_i,
  input  logic [DATA_WIDTH-1:0]            data2_i,
  input  logic [NUM_STAGES*DATA_WIDTH-1:0] zeta_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [DATA_WIDTH-1:0]            data1_o,
  output logic [DATA_WIDTH-1:0]            data2_o,
  output logic [1:0]                       mode_o,
  output logic                             busy_o
);

  localparam int unsigned ZW = NUM_STAGES * DATA_WIDTH;

  logic                  en;
  logic                  valid_chain [0:NUM_STAGES];
  logic [1:0]            mode_chain  [0:NUM_STAGES];
  logic [DATA_WIDTH-1:0] a_chain     [0:NUM_STAGES];
  logic [DATA_WIDTH-1:0] b_chain     [0:NUM_STAGES];
  logic [ZW-1:0]         zeta_chain  [0:NUM_STAGES];
  logic [ZW-1:0]         zeta_tail_unused;
  logic [NUM_STAGES-1:0] stage_busy;

  assign en         = !out_valid_o || out_ready_i;
  assign in_ready_o = en && !clear_i;

  assign valid_chain[0] = in_valid_i && in_ready_o;
  assign mode_chain[0]  = mode_i;
  assign a_chain[0]     = data1_i;
  assign b_chain[0]     = data2_i;
  assign zeta_chain[0]  = zeta_i;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    bu_stage #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_STAGES (NUM_STAGES),
      .STAGE      (k),
      .Q          (Q)
    ) u_stage (
      .clk       (clk_i),
      .rst_n     (reset_ni),
      .en        (en),
      .clear     (clear_i),
      .in_valid  (valid_chain[k]),
      .in_mode   (mode_chain[k]),
      .in_a      (a_chain[k]),
      .in_b      (b_chain[k]),
      .in_zeta   (zeta_chain[k]),
      .out_valid (valid_chain[k+1]),
      .out_mode  (mode_chain[k+1]),
      .out_a     (a_chain[k+1]),
      .out_b     (b_chain[k+1]),
      .out_zeta  (zeta_chain[k+1]),
      .busy      (stage_busy[k])
    );
  end

  // Twiddles leaving the last stage have no consumer.
  assign zeta_tail_unused = zeta_chain[NUM_STAGES];

  assign out_valid_o = valid_chain[NUM_STAGES];
  assign mode_o      = mode_chain[NUM_STAGES];
  assign data1_o     = a_chain[NUM_STAGES];
  assign data2_o     = b_chain[NUM_STAGES];
  assign busy_o      = |stage_busy;

endmodule
